// File: rtl/cordic_pkg.sv
// cordic_pkg: widths, Q1.20 constants and the accumulator state type shared by
// the CORDIC cosine unit and its downstream accumulator.
package cordic_pkg;

   localparam int COS_W = 21;
   localparam int ACC_W = 32;
   localparam int CNT_W = 16;

   localparam logic [COS_W-1:0] ONE = 21'h100000;

   typedef enum logic [1:0] {
      ACC,
      DRAIN,
      PRESENT
   } acc_state_t;

endpackage

// File: rtl/cordic_accumulator_if.sv
// cordic_accumulator_if: sample stream in, snapshot handshake out.
// The master side is the producer/host, the slave side is the accumulator.
interface cordic_accumulator_if #(
   parameter int DATA_W = cordic_pkg::COS_W,
   parameter int ACC_W  = cordic_pkg::ACC_W,
   parameter int CNT_W  = cordic_pkg::CNT_W
);

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              sum_req;
   logic              sum_valid;
   logic              sum_ack;
   logic [ACC_W-1:0]  sum_data;
   logic [CNT_W-1:0]  sum_count;
   logic              overflow;

   modport master (
      output in_valid, in_data, sum_req, sum_ack,
      input  in_ready, sum_valid, sum_data, sum_count, overflow
   );

   modport slave (
      input  in_valid, in_data, sum_req, sum_ack,
      output in_ready, sum_valid, sum_data, sum_count, overflow
   );

endinterface

// File: rtl/cordic_accumulator_sat_add.sv
// sat_add: unsigned W-bit adder that clamps to all ones on carry out and
// flags the clamp, so callers can keep a sticky overflow bit.
module sat_add #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         ovf
);

   logic [W:0] raw;

   // Widen by one bit so the carry out directly signals saturation.
   always_comb begin
      raw = {1'b0, a} + {1'b0, b};
      ovf = raw[W];
      sum = raw[W] ? '1 : raw[W-1:0];
   end

endmodule

// File: rtl/cordic_accumulator.sv
// cordic_accumulator: sums a stream of Q1.20 cosine samples into a saturating
// Q12.20 total with a sample count, and hands both to the host on request
// with read-and-clear semantics.
module cordic_accumulator
   import cordic_pkg::*;
#(
   parameter int DATA_W = cordic_pkg::COS_W,
   parameter int ACC_W  = cordic_pkg::ACC_W,
   parameter int CNT_W  = cordic_pkg::CNT_W
) (
   input  logic                clock,
   input  logic                aclr_n,
   input  logic                clk_en,
   input  logic                clear,
   cordic_accumulator_if.slave bus
);

   acc_state_t        state;
   acc_state_t        state_next;
   logic              pipe_valid;
   logic [DATA_W-1:0] pipe_data;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_sum;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_sum;
   logic              acc_ovf;
   logic              cnt_ovf;
   logic              overflow;
   logic              accept;
   logic              ack_take;
   logic              in_ready_c;
   logic              sum_valid_c;
   logic [ACC_W-1:0]  sum_data_c;
   logic [CNT_W-1:0]  sum_count_c;

   sat_add #(.W(ACC_W)) u_sum_add (
      .a   (acc),
      .b   ({{(ACC_W-DATA_W){1'b0}}, pipe_data}),
      .sum (acc_sum),
      .ovf (acc_ovf)
   );

   sat_add #(.W(CNT_W)) u_cnt_add (
      .a   (count),
      .b   (CNT_W'(1)),
      .sum (count_sum),
      .ovf (cnt_ovf)
   );

   // State register; clk_en low freezes the FSM and therefore every output.
   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         state <= ACC;
      end else if (clk_en) begin
         state <= state_next;
      end
   end

   // Next-state and output decode; clear overrides any transition back to ACC.
   always_comb begin
      state_next  = state;
      in_ready_c  = 1'b0;
      accept      = 1'b0;
      ack_take    = 1'b0;
      sum_valid_c = 1'b0;
      sum_data_c  = '0;
      sum_count_c = '0;
      case (state)
         ACC: begin
            in_ready_c = clk_en;
            accept     = bus.in_valid & clk_en & ~clear;
            if (bus.sum_req) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            state_next = PRESENT;
         end
         PRESENT: begin
            sum_valid_c = 1'b1;
            sum_data_c  = acc;
            sum_count_c = count;
            if (bus.sum_ack) begin
               ack_take   = 1'b1;
               state_next = ACC;
            end
         end
         default: begin
            state_next = ACC;
         end
      endcase
      if (clear) begin
         state_next = ACC;
      end
   end

   // Two-stage datapath: register the accepted sample, then fold it into the
   // saturating sum and count one edge later; clear and ack empty everything.
   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         acc        <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         pipe_valid <= 1'b0;
         pipe_data  <= '0;
      end else if (clk_en) begin
         if (clear || ack_take) begin
            acc        <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            pipe_valid <= 1'b0;
         end else begin
            pipe_valid <= accept;
            if (accept) begin
               pipe_data <= bus.in_data;
            end
            if (pipe_valid) begin
               acc   <= acc_sum;
               count <= count_sum;
               if (acc_ovf || cnt_ovf) begin
                  overflow <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.sum_valid = sum_valid_c;
   assign bus.sum_data  = sum_data_c;
   assign bus.sum_count = sum_count_c;
   assign bus.overflow  = overflow;

endmodule

// File: tb/tb_cordic_accumulator.sv
// tb_cordic_accumulator: directed and randomized checks of the cosine sample
// accumulator against a plain-arithmetic model of the running sum and count.
module tb_cordic_accumulator;
   import cordic_pkg::*;

   logic clock;
   logic aclr_n;
   logic clk_en;
   logic clear;

   int total;
   int bad;

   longint model_sum;
   longint model_cnt;
   bit     model_ovf;

   logic              rnd_valid;
   logic              rnd_en;
   logic [COS_W-1:0]  rnd_data;
   int                rnd_n;

   cordic_accumulator_if bus ();

   cordic_accumulator dut (
      .clock  (clock),
      .aclr_n (aclr_n),
      .clk_en (clk_en),
      .clear  (clear),
      .bus    (bus)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [COS_W-1:0] data,
                                input logic req, input logic ack);
      bus.in_valid = valid;
      bus.in_data  = data;
      bus.sum_req  = req;
      bus.sum_ack  = ack;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic model_clear();
      model_sum = 0;
      model_cnt = 0;
      model_ovf = 1'b0;
   endtask

   task automatic model_add(input logic [COS_W-1:0] d);
      model_sum = model_sum + longint'(d);
      if (model_sum > 64'hFFFF_FFFF) begin
         model_sum = 64'hFFFF_FFFF;
         model_ovf = 1'b1;
      end
      model_cnt = model_cnt + 1;
      if (model_cnt > 65535) begin
         model_cnt = 65535;
         model_ovf = 1'b1;
      end
   endtask

   task automatic send_sample(input logic [COS_W-1:0] d);
      applyStimulus(1'b1, d, 1'b0, 1'b0);
      model_add(d);
      step();
   endtask

   task automatic request_snapshot(input string tag, input bit with_sample, input logic [COS_W-1:0] d);
      applyStimulus(with_sample, d, 1'b1, 1'b0);
      if (with_sample) model_add(d);
      step();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput({tag, ".drain_valid"}, 64'(bus.sum_valid), 64'd0);
      checkOutput({tag, ".drain_ready"}, 64'(bus.in_ready), 64'd0);
      checkOutput({tag, ".drain_data"}, 64'(bus.sum_data), 64'd0);
      step();
      checkOutput({tag, ".valid"}, 64'(bus.sum_valid), 64'd1);
      checkOutput({tag, ".data"}, 64'(bus.sum_data), 64'(model_sum));
      checkOutput({tag, ".count"}, 64'(bus.sum_count), 64'(model_cnt));
      checkOutput({tag, ".ovf"}, 64'(bus.overflow), 64'(model_ovf));
      checkOutput({tag, ".present_ready"}, 64'(bus.in_ready), 64'd0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      #1;
      checkOutput({tag, ".ack_ready"}, 64'(bus.in_ready), 64'd0);
      step();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      model_clear();
      checkOutput({tag, ".after_ready"}, 64'(bus.in_ready), 64'd1);
      checkOutput({tag, ".after_valid"}, 64'(bus.sum_valid), 64'd0);
      checkOutput({tag, ".after_data"}, 64'(bus.sum_data), 64'd0);
      checkOutput({tag, ".after_ovf"}, 64'(bus.overflow), 64'd0);
   endtask

   // Directed scenarios followed by randomized batches, then the summary.
   initial begin
      total = 0;
      bad   = 0;
      model_clear();
      aclr_n = 1'b0;
      clk_en = 1'b1;
      clear  = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      #2;
      checkOutput("reset.ready", 64'(bus.in_ready), 64'd1);
      checkOutput("reset.valid", 64'(bus.sum_valid), 64'd0);
      checkOutput("reset.data", 64'(bus.sum_data), 64'd0);
      checkOutput("reset.count", 64'(bus.sum_count), 64'd0);
      checkOutput("reset.ovf", 64'(bus.overflow), 64'd0);
      #1;
      aclr_n = 1'b1;
      step();

      $display("[TB] basic sum");
      send_sample(ONE);
      send_sample(ONE);
      send_sample(ONE);
      request_snapshot("basic", 1'b0, '0);

      $display("[TB] sample in the request cycle");
      send_sample(ONE);
      send_sample(ONE);
      request_snapshot("same_cycle", 1'b1, 21'h080000);

      $display("[TB] saturation");
      for (int i = 0; i < 2048; i++) send_sample(21'h1FFFFF);
      request_snapshot("sat_edge", 1'b0, '0);
      for (int i = 0; i < 2049; i++) send_sample(21'h1FFFFF);
      request_snapshot("sat_over", 1'b0, '0);

      $display("[TB] read-and-clear");
      send_sample(21'h000001);
      request_snapshot("rc", 1'b0, '0);

      $display("[TB] clear in PRESENT");
      send_sample(ONE);
      send_sample(ONE);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      step();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      step();
      checkOutput("clr.present_valid", 64'(bus.sum_valid), 64'd1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      model_clear();
      checkOutput("clr.valid", 64'(bus.sum_valid), 64'd0);
      checkOutput("clr.ready", 64'(bus.in_ready), 64'd1);
      checkOutput("clr.data", 64'(bus.sum_data), 64'd0);
      request_snapshot("clr.after", 1'b0, '0);

      $display("[TB] clear drops in-flight and same-cycle samples");
      send_sample(ONE);
      clear = 1'b1;
      applyStimulus(1'b1, ONE, 1'b0, 1'b0);
      step();
      clear = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      model_clear();
      request_snapshot("clr.drop", 1'b0, '0);

      $display("[TB] clk_en low");
      send_sample(21'h000123);
      clk_en = 1'b0;
      applyStimulus(1'b1, 21'h0ABCDE, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         #1;
         checkOutput("en.ready", 64'(bus.in_ready), 64'd0);
         checkOutput("en.valid", 64'(bus.sum_valid), 64'd0);
         step();
      end
      clk_en = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      request_snapshot("en.after", 1'b0, '0);

      $display("[TB] snapshot held while clk_en low");
      send_sample(ONE);
      send_sample(ONE);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      step();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      step();
      clk_en = 1'b0;
      applyStimulus(1'b1, ONE, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("hold.valid", 64'(bus.sum_valid), 64'd1);
         checkOutput("hold.data", 64'(bus.sum_data), 64'(model_sum));
         checkOutput("hold.count", 64'(bus.sum_count), 64'(model_cnt));
      end
      clk_en = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      step();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      model_clear();
      checkOutput("hold.after_valid", 64'(bus.sum_valid), 64'd0);
      checkOutput("hold.after_ready", 64'(bus.in_ready), 64'd1);

      $display("[TB] async reset in DRAIN");
      send_sample(ONE);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      step();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      aclr_n = 1'b0;
      #1;
      model_clear();
      checkOutput("areset.ready", 64'(bus.in_ready), 64'd1);
      checkOutput("areset.valid", 64'(bus.sum_valid), 64'd0);
      checkOutput("areset.data", 64'(bus.sum_data), 64'd0);
      checkOutput("areset.count", 64'(bus.sum_count), 64'd0);
      checkOutput("areset.ovf", 64'(bus.overflow), 64'd0);
      step();
      checkOutput("areset.held_valid", 64'(bus.sum_valid), 64'd0);
      aclr_n = 1'b1;
      step();
      checkOutput("areset.release_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("areset.release_valid", 64'(bus.sum_valid), 64'd0);
      request_snapshot("areset.after", 1'b0, '0);

      $display("[TB] randomized batches");
      for (int round = 0; round < 4; round++) begin
         rnd_n = int'($urandom_range(5, 40));
         for (int i = 0; i < rnd_n; i++) begin
            rnd_valid = ($urandom_range(0, 3) != 0);
            rnd_en    = ($urandom_range(0, 4) != 0);
            rnd_data  = COS_W'($urandom_range(0, 32'h1FFFFF));
            clk_en    = rnd_en;
            applyStimulus(rnd_valid, rnd_data, 1'b0, 1'b0);
            #1;
            checkOutput("rand.ready", 64'(bus.in_ready), 64'(rnd_en));
            if (rnd_valid && rnd_en) model_add(rnd_data);
            step();
         end
         clk_en = 1'b1;
         applyStimulus(1'b0, '0, 1'b0, 1'b0);
         request_snapshot("rand", 1'b0, '0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cordic_accumulator.md
Name: cordic_accumulator

Overview:
- Downstream consumer of the CORDIC cosine unit. Accepts a stream of 21-bit unsigned Q1.20 cosine samples, which are the CORDIC x register at completion.
- Keeps a wide saturating running sum and a sample count.
- On request, snapshots both to the host-side reader and clears them ("read-and-clear"). This lets software batch cosine evaluations without a float add per sample.

Parameters:
- DATA_W, 21, sample width (unsigned Q1.20; 1.0 = 21'h100000).
- ACC_W, 32, accumulator width (unsigned Q12.20).
- CNT_W, 16, sample-counter width.

Ports:
- clock  in  1  single clock, all state on rising edge.
- aclr_n  in  1  asynchronous active-low reset.
- clk_en  in  1  global enable; low freezes all state and holds all outputs.
- clear  in  1  synchronous clear; highest priority after reset.
- in_valid  in  1  sample present.
- in_data  in  DATA_W  cosine sample, Q1.20 unsigned.
- in_ready  out  1  block can accept a sample this cycle.
- sum_req  in  1  request snapshot, sampled only in ACC.
- sum_valid  out  1  snapshot presented.
- sum_ack  in  1  reader consumed the snapshot.
- sum_data  out  ACC_W  accumulated sum.
- sum_count  out  CNT_W  samples included in sum_data.
- overflow  out  1  sticky; the sum or the count saturated since the last clear.

Behaviour:
- Reset (aclr_n=0, async): state=ACC, acc=0, count=0, pipe_valid=0, pipe_data=0, overflow=0. Outputs: in_ready=1, sum_valid=0, sum_data=0, sum_count=0.
- Pipeline: an accepted sample (in_valid & in_ready & clk_en) is registered into pipe_data with pipe_valid=1 at edge E1. At E2, acc <= sat(acc + zero-extended pipe_data) and count <= sat(count+1). The sum therefore reflects a sample 2 edges after acceptance.
- Saturation:
  - Sum: if acc + sample exceeds 2^ACC_W-1, acc = all ones and overflow <= 1.
  - Count: saturates at 2^CNT_W-1 and also sets overflow.
  - overflow is sticky until a sum_ack handshake or clear.
- States:
  - ACC: in_ready=1.
    - sum_req=1 -> DRAIN.
    - A sample accepted in the same cycle as sum_req is included in the snapshot.
  - DRAIN: one cycle; in_ready=0; the pending pipe entry is added -> PRESENT.
  - PRESENT: in_ready=0, sum_valid=1.
    - sum_data=acc, sum_count=count; both held stable.
    - On sum_ack=1: acc=0, count=0, overflow=0, pipe_valid=0 -> ACC.
    - in_ready returns to 1 the cycle after the ack.
- Latency: sum_req in cycle t -> sum_valid=1 in cycle t+2, assuming clk_en is held high.
- sum_data and sum_count read 0 outside PRESENT.
- sum_req outside ACC is ignored. sum_ack outside PRESENT is ignored.
- clear=1 in any state, with clk_en high:
  - acc, count, overflow and pipe_valid all go to 0; state -> ACC.
  - An in_valid in the same cycle is dropped.
  - An in-flight snapshot is discarded without a handshake.
- clk_en=0: no state change, no acceptance, outputs held. in_ready is forced 0 while clk_en=0.
- Reset asserted mid-snapshot returns to reset values immediately, with no glitch on sum_valid beyond the asynchronous deassert.

Decomposition:
- Shared package cordic_pkg:
  - COS_W=21, ACC_W=32, CNT_W=16.
  - Q1.20 ONE constant 21'h100000.
  - Enumerated state type {ACC, DRAIN, PRESENT}.
- One natural sub-module: sat_add. A parameterised unsigned saturating adder with an overflow flag, used for both the sum and the count.

Test Plan:
- Basic sum: three samples of 21'h100000 back-to-back, then sum_req -> sum_valid 2 cycles later; sum_data=32'h00300000, sum_count=3, overflow=0.
- Same-cycle sample and request: in_valid with 21'h080000 and sum_req in the same cycle after two 21'h100000 samples -> sum_data=32'h00280000, sum_count=3. in_ready stays 0 until the cycle after sum_ack.
- Saturation: 2048 samples of 21'h1FFFFF -> sum_data=32'hFFFFF800, overflow=0. One more sample -> sum_data=32'hFFFFFFFF, overflow=1.
- Read-and-clear: after sum_ack, one sample of 21'h000001 and a request -> sum_data=1, sum_count=1, overflow=0.
- Clear and clk_en:
  - clear asserted in PRESENT -> sum_valid=0 next cycle, state ACC, acc=0.
  - clk_en low for 5 cycles with in_valid high -> no count change.
- Async reset: aclr_n pulsed low mid-DRAIN -> all outputs return to reset values immediately; in_ready=1 after release.
